// File: rtl/md_sched_if.sv
// Mult/div unit bus: E-stage issue, D-stage hazard query, busy/stall and HI/LO results.
interface md_sched_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        d_md_use;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, rs_val, rt_val, d_md_use,
      input  busy, stall, hi, lo
   );

   modport slave (
      input  start, op, rs_val, rt_val, d_md_use,
      output busy, stall, hi, lo
   );
endinterface

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler with HI/LO result registers.
// The operation is timed by a down-counter. The result is computed from the
// latched operands and committed on the last busy edge.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | accepting MULT/DIV starts and MTHI/MTLO writes
// RUN    | counting down busy cycles; starts of every kind are ignored
module md_sched #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input logic       clk,
   input logic       reset,
   md_sched_if.slave md
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [31:0] r_rs;
   logic [31:0] r_rt;
   logic [2:0]  r_op;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_idle;
   logic        w_accept;
   logic        w_mthi;
   logic        w_mtlo;
   logic        w_done;
   logic        w_is_div;
   logic        w_div_signed;
   logic        w_write;

   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [31:0] w_dvd;
   logic [31:0] w_dvs;
   logic [31:0] w_uq;
   logic [31:0] w_ur;
   logic [31:0] w_q;
   logic [31:0] w_r;
   logic [31:0] w_res_hi;
   logic [31:0] w_res_lo;

   assign w_idle   = (r_state == S_IDLE);
   assign w_accept = w_idle && md.start && !md.op[2];
   assign w_mthi   = w_idle && md.start && (md.op == 3'd4);
   assign w_mtlo   = w_idle && md.start && (md.op == 3'd5);
   assign w_done   = (r_state == S_RUN) && (r_cnt == 4'd1);

   // Datapath works on the latched operands only, so operand buses may change during RUN.
   assign w_is_div     = r_op[1];
   assign w_div_signed = (r_op == 3'd2);

   assign w_prod_s = $signed({{32{r_rs[31]}}, r_rs}) * $signed({{32{r_rt[31]}}, r_rt});
   assign w_prod_u = {32'd0, r_rs} * {32'd0, r_rt};

   // Signed division runs on magnitudes through the same unsigned divider. This also
   // makes 0x80000000 / -1 come out as quotient 0x80000000, remainder 0.
   assign w_abs_a = r_rs[31] ? (32'd0 - r_rs) : r_rs;
   assign w_abs_b = r_rt[31] ? (32'd0 - r_rt) : r_rt;
   assign w_dvd   = w_div_signed ? w_abs_a : r_rs;
   assign w_dvs   = w_div_signed ? w_abs_b : r_rt;
   assign w_uq    = (w_dvs == 32'd0) ? 32'd0 : (w_dvd / w_dvs);
   assign w_ur    = (w_dvs == 32'd0) ? 32'd0 : (w_dvd % w_dvs);
   assign w_q     = (w_div_signed && (r_rs[31] ^ r_rt[31])) ? (32'd0 - w_uq) : w_uq;
   assign w_r     = (w_div_signed && r_rs[31]) ? (32'd0 - w_ur) : w_ur;

   assign w_res_hi = w_is_div ? w_r : (r_op[0] ? w_prod_u[63:32] : w_prod_s[63:32]);
   assign w_res_lo = w_is_div ? w_q : (r_op[0] ? w_prod_u[31:0]  : w_prod_s[31:0]);

   // A zero divisor still runs the full busy period but leaves HI/LO untouched.
   assign w_write = w_done && !(w_is_div && (r_rt == 32'd0));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: enter RUN on an accepted mult/div, leave when the count reaches one.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
         S_RUN:   if (w_done)   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Counter, operand latches and HI/LO registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= 4'd0;
         r_rs  <= 32'd0;
         r_rt  <= 32'd0;
         r_op  <= 3'd0;
         r_hi  <= 32'd0;
         r_lo  <= 32'd0;
      end else begin
         if (w_accept) begin
            r_cnt <= md.op[1] ? 4'(DIV_CYC) : 4'(MULT_CYC);
            r_rs  <= md.rs_val;
            r_rt  <= md.rt_val;
            r_op  <= md.op;
         end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_write) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end
         if (w_mthi) r_hi <= md.rs_val;
         if (w_mtlo) r_lo <= md.rs_val;
      end
   end

   // Outputs: busy tracks RUN; stall is combinational so the D stage freezes on the issue cycle.
   always_comb begin
      md.busy  = (r_state == S_RUN);
      md.stall = !reset && md.d_md_use && ((r_state == S_RUN) || (md.start && !md.op[2]));
      md.hi    = r_hi;
      md.lo    = r_lo;
   end

endmodule
